// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the two requesters, the arbiter and the uart_tx serializer.
// Latency: none, wires only.
// Backpressure: reqN_ready pulses and tx_busy are the only stall signals carried here.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic       grant;
    logic       locked;

    // Arbiter side: takes requester bytes and the serializer's busy, drives everything else.
    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output tx_data, tx_send,
        input  tx_busy,
        output grant, locked
    );

    // Environment side: requesters plus the serializer.
    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  tx_data, tx_send,
        output tx_busy,
        input  grant, locked
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one uart_tx between two byte requesters.
// Latency: valid to ready 1 cycle; the byte appears on tx_data with tx_send on that ready cycle.
// Backpressure: tx_send/tx_data hold until uart_tx is not busy; requesters hold until ready pulses.
module uart_tx_arbiter #(
    parameter int unsigned      GAP_W   = 20,
    parameter logic [GAP_W-1:0] MAX_GAP = 20'd1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        NEXT = 2'd2
    } state_t;

    // Gap count at which the next idle NEXT cycle forces the release.
    localparam logic [GAP_W-1:0] GAP_LAST = MAX_GAP - 1'b1;

    state_t           state;
    logic [7:0]       tx_data_r;
    logic             tx_send_r;
    logic             req0_ready_r;
    logic             req1_ready_r;
    logic             grant_r;
    logic             locked_r;
    logic             last_r;
    logic             prio_r;
    logic [GAP_W-1:0] gap_cnt;

    logic             idle_pick;
    logic [7:0]       pick_data;
    logic             pick_last;
    logic             own_valid;
    logic [7:0]       own_data;
    logic             own_last;
    logic             accept;

    // Winner selection in IDLE and byte lanes of the current owner in NEXT.
    always_comb begin
        idle_pick = (bus.req0_valid && bus.req1_valid) ? prio_r : bus.req1_valid;
        pick_data = idle_pick ? bus.req1_data : bus.req0_data;
        pick_last = idle_pick ? bus.req1_last : bus.req0_last;
        own_valid = grant_r ? bus.req1_valid : bus.req0_valid;
        own_data  = grant_r ? bus.req1_data  : bus.req0_data;
        own_last  = grant_r ? bus.req1_last  : bus.req0_last;
        accept    = tx_send_r && !bus.tx_busy;
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tx_send_r    <= 1'b0;
            tx_data_r    <= 8'hFF;
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
            grant_r      <= 1'b0;
            locked_r     <= 1'b0;
            last_r       <= 1'b0;
            prio_r       <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        grant_r      <= idle_pick;
                        locked_r     <= 1'b1;
                        req0_ready_r <= !idle_pick;
                        req1_ready_r <= idle_pick;
                        tx_data_r    <= pick_data;
                        last_r       <= pick_last;
                        tx_send_r    <= 1'b1;
                        gap_cnt      <= '0;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        tx_send_r <= 1'b0;
                        if (last_r) begin
                            locked_r <= 1'b0;
                            prio_r   <= !grant_r;
                            state    <= IDLE;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (own_valid) begin
                        req0_ready_r <= !grant_r;
                        req1_ready_r <= grant_r;
                        tx_data_r    <= own_data;
                        last_r       <= own_last;
                        tx_send_r    <= 1'b1;
                        gap_cnt      <= '0;
                        state        <= SEND;
                    end else if (gap_cnt >= GAP_LAST) begin
                        // Owner stalled too long: saturate and hand the line back.
                        gap_cnt  <= MAX_GAP;
                        locked_r <= 1'b0;
                        prio_r   <= !grant_r;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_data    = tx_data_r;
    assign bus.tx_send    = tx_send_r;
    assign bus.req0_ready = req0_ready_r;
    assign bus.req1_ready = req1_ready_r;
    assign bus.grant      = grant_r;
    assign bus.locked     = locked_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a packet-level round-robin reference model.
// Latency: checks sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: tx_busy is randomised or held by directed steps; requesters obey ready pulses.
module tb_uart_tx_arbiter;

    localparam logic [19:0] GAP = 20'd16;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic [7:0] expq[$];

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.GAP_W(20), .MAX_GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req0_last  = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        bus.req1_last  = 1'b0;
        bus.tx_busy    = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        quiet_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Expected UART byte order: whole packets, round-robin when both sides have one pending.
    task automatic build_expected();
        int j0 = 0;
        int j1 = 0;
        bit p  = 1'b0;
        bit r;
        expq.delete();
        while (j0 < src0.size() || j1 < src1.size()) begin
            if (j0 < src0.size() && j1 < src1.size()) r = p;
            else r = (j1 < src1.size());
            if (!r) begin
                do begin
                    expq.push_back(src0[j0][7:0]);
                    j0++;
                end while (!src0[j0-1][8]);
            end else begin
                do begin
                    expq.push_back(src1[j1][7:0]);
                    j1++;
                end while (!src1[j1-1][8]);
            end
            p = !r;
        end
    endtask

    // Streams src0/src1 into the DUT, plays a random uart_tx, and scores the accepted bytes.
    task automatic run_traffic(input int busy_low_pct, input int st1, input bit gaps);
        int   i0 = 0;
        int   i1 = 0;
        int   g0 = 0;
        int   g1 = 0;
        int   cyc = 0;
        logic prev_wait = 1'b0;
        logic [7:0] prev_data = 8'h00;
        build_expected();
        while (expq.size() > 0 && cyc < 4000) begin
            bus.req0_valid = (i0 < src0.size()) && (g0 == 0);
            bus.req0_data  = (i0 < src0.size()) ? src0[i0][7:0] : 8'h00;
            bus.req0_last  = (i0 < src0.size()) ? src0[i0][8]   : 1'b0;
            bus.req1_valid = (i1 < src1.size()) && (g1 == 0) && (cyc >= st1);
            bus.req1_data  = (i1 < src1.size()) ? src1[i1][7:0] : 8'h00;
            bus.req1_last  = (i1 < src1.size()) ? src1[i1][8]   : 1'b0;
            if (g0 > 0) g0--;
            if (g1 > 0) g1--;
            bus.tx_busy = ($urandom_range(99) >= busy_low_pct);
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                check("ready_exclusive", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
                check("ready_grant", {31'd0, bus.grant}, {31'd0, bus.req1_ready});
                check("ready_locked", {31'd0, bus.locked}, 32'd1);
            end
            if (prev_wait && bus.tx_send)
                check("tx_data_stable", {24'd0, bus.tx_data}, {24'd0, prev_data});
            if (bus.tx_send && !bus.tx_busy) begin
                check("uart_byte", {24'd0, bus.tx_data}, {24'd0, expq.pop_front()});
            end
            prev_wait = bus.tx_send && bus.tx_busy;
            prev_data = bus.tx_data;
            if (bus.req0_ready) begin
                if (gaps && !src0[i0][8] && $urandom_range(1) == 1) g0 = $urandom_range(6, 1);
                i0++;
            end
            if (bus.req1_ready) begin
                if (gaps && !src1[i1][8] && $urandom_range(1) == 1) g1 = $urandom_range(6, 1);
                i1++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        check("bytes_drained", expq.size(), 32'd0);
        check("src0_taken", i0, src0.size());
        check("src1_taken", i1, src1.size());
        quiet_inputs();
        @(negedge clk);
        check("locked_after_last", {31'd0, bus.locked}, 32'd0);
        check("send_after_last", {31'd0, bus.tx_send}, 32'd0);
    endtask

    task automatic gen_random();
        int np;
        int len;
        src0.delete();
        src1.delete();
        np = $urandom_range(3);
        for (int p = 0; p < np; p++) begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) src0.push_back({(b == len - 1), 8'($urandom)});
        end
        np = $urandom_range(3);
        for (int p = 0; p < np; p++) begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) src1.push_back({(b == len - 1), 8'($urandom)});
        end
        if (src0.size() == 0 && src1.size() == 0) src0.push_back({1'b1, 8'($urandom)});
    endtask

    initial begin
        int  n;
        int  bad;
        int  acc;
        bit  found;

        reset = 1'b1;
        quiet_inputs();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_tx_send", {31'd0, bus.tx_send}, 32'd0);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'hFF);
        check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        check("rst_grant", {31'd0, bus.grant}, 32'd0);
        check("rst_locked", {31'd0, bus.locked}, 32'd0);

        // req0 sends "X\r\n"
        do_reset();
        src0 = '{9'h058, 9'h00D, 9'h10A};
        src1.delete();
        run_traffic(40, 0, 1'b0);

        // Two 2-byte packets per side, both valid together: priority alternates
        do_reset();
        src0 = '{9'h041, 9'h142, 9'h045, 9'h146};
        src1 = '{9'h063, 9'h164, 9'h067, 9'h168};
        run_traffic(40, 0, 1'b0);

        // req1 shows up mid-way through a req0 3-byte packet
        do_reset();
        src0 = '{9'h031, 9'h032, 9'h133};
        src1 = '{9'h15A};
        run_traffic(25, 3, 1'b0);

        // Owner stalls after one non-last byte; lock is released after MAX_GAP idle cycles
        do_reset();
        bus.tx_busy    = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h11;
        bus.req0_last  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h22;
        bus.req1_last  = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.tx_send && !bus.tx_busy) begin
                found = 1'b1;
                check("gap_first_byte", {24'd0, bus.tx_data}, 32'h11);
            end
        end
        check("gap_accept_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        n   = 0;
        bad = 0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) bad++;
            if (bus.locked) n++;
            else found = 1'b1;
        end
        check("gap_locked_cycles", n, 32'd16);
        check("gap_no_ready_while_stalled", bad, 32'd0);
        @(negedge clk);
        check("gap_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
        check("gap_req1_grant", {31'd0, bus.grant}, 32'd1);

        // tx_busy held high for 500 cycles with a byte pending
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h5A;
        bus.req0_last  = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.tx_send) found = 1'b1;
        end
        check("hold_send_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (!(bus.tx_send === 1'b1 && bus.tx_data === 8'h5A)) bad++;
        end
        check("hold_stable", bad, 32'd0);
        @(posedge clk);
        #1;
        bus.tx_busy = 1'b0;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.tx_send && !bus.tx_busy) acc++;
            @(posedge clk);
            #1;
            bus.tx_busy = 1'b1;
        end
        check("hold_one_accept", acc, 32'd1);
        check("hold_send_low", {31'd0, bus.tx_send}, 32'd0);
        check("hold_single_byte_unlock", {31'd0, bus.locked}, 32'd0);

        // Reset asserted while a byte sits in SEND
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h33;
        bus.req0_last  = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.tx_send) found = 1'b1;
        end
        check("rsend_send_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rsend_tx_send", {31'd0, bus.tx_send}, 32'd0);
        check("rsend_tx_data", {24'd0, bus.tx_data}, 32'hFF);
        check("rsend_locked", {31'd0, bus.locked}, 32'd0);
        check("rsend_ready0", {31'd0, bus.req0_ready}, 32'd0);
        check("rsend_ready1", {31'd0, bus.req1_ready}, 32'd0);
        check("rsend_grant", {31'd0, bus.grant}, 32'd0);
        bus.req0_valid = 1'b0;
        reset = 1'b0;

        // Randomised packet mixes with random busy pattern and short mid-packet stalls
        for (int it = 0; it < 10; it++) begin
            do_reset();
            gen_random();
            run_traffic(33, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
